// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers.
//   fifo_addr_w   : pointer width for a given depth
//   fifo_status_t : bundled status flags, reusable by other FIFO variants
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port FIFO storage: synchronous write, asynchronous read. Not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 7,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                                clk,
  input  logic                                we,
  input  logic [fifo_addr_w(DEPTH)-1:0]       waddr,
  input  logic [DATA_WIDTH-1:0]               wdata,
  input  logic [fifo_addr_w(DEPTH)-1:0]       raddr,
  output logic [DATA_WIDTH-1:0]               rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// overflow/underflow pulses, synchronous flush and optional FWFT read.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : synchronous clear of contents (rd_data held)
//   wr_en, wr_data : write request and data
//   rd_en          : read/pop request
//   rd_data        : read data, rd_valid marks it valid
//   full, empty, almost_full, almost_empty : decoded from count
//   count          : occupancy
//   overflow, underflow : one-cycle pulses for rejected write/read
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 7,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter bit          FWFT          = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned ADDR_W = fifo_addr_w(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  // Parameter legality
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH < DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_param: need 0 < AEMPTY_THRESH < AFULL_THRESH < DEPTH");
  end

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  fifo_status_t          status_c;

  // Flags decode from the registered count so they track it in the same cycle
  always_comb begin
    status_c              = '0;
    status_c.full         = (count == CNT_W'(DEPTH));
    status_c.empty        = (count == '0);
    status_c.almost_full  = (count >= CNT_W'(AFULL_THRESH));
    status_c.almost_empty = (count <= CNT_W'(AEMPTY_THRESH));
    status_c.overflow     = overflow;
    status_c.underflow    = underflow;
  end

  assign full         = status_c.full;
  assign empty        = status_c.empty;
  assign almost_full  = status_c.almost_full;
  assign almost_empty = status_c.almost_empty;

  // Acceptance uses pre-edge full/empty: a same-cycle pop never frees room
  // for a write, and a same-cycle push never feeds a read.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign mem_we = wr_acc & rst_n & ~flush;

  always_comb begin
    count_next = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, occupancy and error pulses; flush clears like reset
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      count     <= count_next;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Read port: head word shown directly in FWFT, registered on pop otherwise
  if (FWFT) begin : g_fwft
    assign rd_data  = mem_rdata;
    assign rd_valid = ~status_c.empty;
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (flush) begin
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: one standard-mode and one FWFT instance, a queue
// reference model, a vector table, directed corner sequences and random traffic.
module tb_sync_fifo_param;

  localparam int unsigned DW    = 7;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFT   = DEPTH - 2;
  localparam int unsigned AET   = 2;

  logic          clk;
  logic          rst_n;
  logic          fl  [2];
  logic          we  [2];
  logic          re  [2];
  logic [DW-1:0] wd  [2];
  logic [DW-1:0] rdd [2];
  logic          rv  [2];
  logic          fu  [2];
  logic          em  [2];
  logic          af  [2];
  logic          ae  [2];
  logic [4:0]    cnt [2];
  logic          ov  [2];
  logic          un  [2];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq0 [$];
  logic [DW-1:0] mq1 [$];
  logic          m_rv  [2];
  logic [DW-1:0] m_rd  [2];
  logic          m_ovf [2];
  logic          m_unf [2];

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT),
                    .AEMPTY_THRESH(AET), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]), .wr_en(we[0]), .wr_data(wd[0]),
    .rd_en(re[0]), .rd_data(rdd[0]), .rd_valid(rv[0]), .full(fu[0]),
    .empty(em[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]),
    .overflow(ov[0]), .underflow(un[0]));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT),
                    .AEMPTY_THRESH(AET), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]), .wr_en(we[1]), .wr_data(wd[1]),
    .rd_en(re[1]), .rd_data(rdd[1]), .rd_valid(rv[1]), .full(fu[1]),
    .empty(em[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]),
    .overflow(ov[1]), .underflow(un[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input int k, input logic f, input logic w, input logic r,
                        input logic [DW-1:0] d);
    fl[k] = f;
    we[k] = w;
    re[k] = r;
    wd[k] = d;
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [DW-1:0] mhead(input int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  // FIFO behaviour as a queue: decisions use the occupancy before the edge
  task automatic model_step(input int k);
    int sz;
    sz = msize(k);
    if (!rst_n || fl[k]) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      m_rv[k]  = 1'b0;
      m_ovf[k] = 1'b0;
      m_unf[k] = 1'b0;
      if (!rst_n) m_rd[k] = '0;
    end else begin
      m_ovf[k] = we[k] && (sz == DEPTH);
      m_unf[k] = re[k] && (sz == 0);
      m_rv[k]  = 1'b0;
      if (re[k] && sz > 0) begin
        m_rd[k] = (k == 0) ? mq0.pop_front() : mq1.pop_front();
        m_rv[k] = 1'b1;
      end
      if (we[k] && sz < DEPTH) begin
        if (k == 0) mq0.push_back(wd[k]); else mq1.push_back(wd[k]);
      end
    end
  endtask

  task automatic check_dut(input int k);
    int sz;
    sz = msize(k);
    chk($sformatf("m%0d_count", k), 32'(cnt[k]), 32'(sz));
    chk($sformatf("m%0d_full", k), 32'(fu[k]), 32'(sz == DEPTH));
    chk($sformatf("m%0d_empty", k), 32'(em[k]), 32'(sz == 0));
    chk($sformatf("m%0d_afull", k), 32'(af[k]), 32'(sz >= AFT));
    chk($sformatf("m%0d_aempty", k), 32'(ae[k]), 32'(sz <= AET));
    chk($sformatf("m%0d_ovf", k), 32'(ov[k]), 32'(m_ovf[k]));
    chk($sformatf("m%0d_unf", k), 32'(un[k]), 32'(m_unf[k]));
    if (k == 0) begin
      chk("m0_rd_valid", 32'(rv[0]), 32'(m_rv[0]));
      chk("m0_rd_data", 32'(rdd[0]), 32'(m_rd[0]));
    end else begin
      chk("m1_rd_valid", 32'(rv[1]), 32'(sz > 0));
      if (sz > 0) chk("m1_rd_data", 32'(rdd[1]), 32'(mhead(1)));
    end
  endtask

  // One clock: model and DUT both step on the edge, outputs sampled 1 time unit later
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  typedef struct {
    logic          rst_n;
    logic          flush;
    logic          wr;
    logic          rd;
    logic [DW-1:0] wd;
    int            cnt;
    logic          full;
    logic          empty;
    logic          ae;
    logic          ovf;
    logic          unf;
    logic          rv;
    logic [DW-1:0] rdd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) set_in(k, 1'b0, 1'b0, 1'b0, '0);
    m_rv  = '{1'b0, 1'b0};
    m_rd  = '{'0, '0};
    m_ovf = '{1'b0, 1'b0};
    m_unf = '{1'b0, 1'b0};

    //          rst  fl   wr   rd   wd     cnt full empty ae  ovf  unf  rv   rdd
    tbl[0] = '{1'b0,1'b0,1'b0,1'b0,7'h00, 0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,7'h00};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b1,7'h55, 1, 1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,7'h00};
    tbl[2] = '{1'b1,1'b0,1'b0,1'b0,7'h00, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,7'h00};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b1,7'h00, 0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,7'h55};
    tbl[4] = '{1'b1,1'b0,1'b0,1'b1,7'h00, 0, 1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,7'h55};
    tbl[5] = '{1'b1,1'b0,1'b1,1'b0,7'h11, 1, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,7'h55};
    tbl[6] = '{1'b1,1'b0,1'b1,1'b0,7'h22, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,7'h55};
    tbl[7] = '{1'b1,1'b0,1'b1,1'b1,7'h33, 2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,7'h11};
    tbl[8] = '{1'b1,1'b1,1'b1,1'b0,7'h44, 0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,7'h11};
    tbl[9] = '{1'b1,1'b0,1'b0,1'b0,7'h00, 0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,7'h11};

    // Vector table on the standard-mode instance
    for (int i = 0; i < 10; i++) begin
      rst_n = tbl[i].rst_n;
      set_in(0, tbl[i].flush, tbl[i].wr, tbl[i].rd, tbl[i].wd);
      cycle();
      chk($sformatf("v%0d_count", i), 32'(cnt[0]), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(fu[0]), 32'(tbl[i].full));
      chk($sformatf("v%0d_empty", i), 32'(em[0]), 32'(tbl[i].empty));
      chk($sformatf("v%0d_aempty", i), 32'(ae[0]), 32'(tbl[i].ae));
      chk($sformatf("v%0d_ovf", i), 32'(ov[0]), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(un[0]), 32'(tbl[i].unf));
      chk($sformatf("v%0d_rv", i), 32'(rv[0]), 32'(tbl[i].rv));
      chk($sformatf("v%0d_rdd", i), 32'(rdd[0]), 32'(tbl[i].rdd));
    end
    set_in(0, 1'b0, 1'b0, 1'b0, '0);

    // Fill to full, overflow once, drain in order
    for (int i = 1; i <= 16; i++) begin
      set_in(0, 1'b0, 1'b1, 1'b0, DW'(i));
      cycle();
      chk("fill_afull", 32'(af[0]), 32'(i >= 14));
      chk("fill_full", 32'(fu[0]), 32'(i == 16));
    end
    set_in(0, 1'b0, 1'b1, 1'b0, 7'h11);
    cycle();
    chk("ovf_pulse", 32'(ov[0]), 32'd1);
    chk("ovf_count", 32'(cnt[0]), 32'd16);
    set_in(0, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    chk("ovf_clear", 32'(ov[0]), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      set_in(0, 1'b0, 1'b0, 1'b1, '0);
      cycle();
      chk("drain_rv", 32'(rv[0]), 32'd1);
      chk("drain_data", 32'(rdd[0]), 32'(i));
    end
    set_in(0, 1'b0, 1'b0, 1'b0, '0);
    cycle();

    // Steady occupancy of 8 with pointer wrap
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1'b0, 1'b1, 1'b0, DW'(8'h20 + i));
      cycle();
    end
    for (int i = 0; i < 40; i++) begin
      set_in(0, 1'b0, 1'b1, 1'b1, DW'(8'h40 + i));
      cycle();
      chk("steady_count", 32'(cnt[0]), 32'd8);
      chk("steady_data", 32'(rdd[0]), (i < 8) ? 32'(8'h20 + i) : 32'(8'h40 + i - 8));
    end
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1'b0, 1'b0, 1'b1, '0);
      cycle();
    end
    set_in(0, 1'b0, 1'b0, 1'b0, '0);

    // FWFT: head visible without rd_en, pop empties it
    set_in(1, 1'b0, 1'b1, 1'b0, 7'h2A);
    cycle();
    chk("fwft_rv", 32'(rv[1]), 32'd1);
    chk("fwft_data", 32'(rdd[1]), 32'h2A);
    set_in(1, 1'b0, 1'b0, 1'b0, '0);
    cycle();
    chk("fwft_hold", 32'(rdd[1]), 32'h2A);
    set_in(1, 1'b0, 1'b0, 1'b1, '0);
    cycle();
    chk("fwft_pop_empty", 32'(em[1]), 32'd1);
    chk("fwft_pop_rv", 32'(rv[1]), 32'd0);
    set_in(1, 1'b0, 1'b0, 1'b0, '0);

    // Flush beats a same-cycle write; reset mid-burst
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b0, 1'b1, 1'b0, DW'(8'h50 + i));
      cycle();
    end
    chk("pre_flush_count", 32'(cnt[0]), 32'd5);
    set_in(0, 1'b1, 1'b1, 1'b0, 7'h7F);
    cycle();
    chk("flush_count", 32'(cnt[0]), 32'd0);
    chk("flush_empty", 32'(em[0]), 32'd1);
    chk("flush_ovf", 32'(ov[0]), 32'd0);
    set_in(0, 1'b0, 1'b1, 1'b0, 7'h61);
    cycle();
    set_in(0, 1'b0, 1'b1, 1'b0, 7'h62);
    cycle();
    set_in(0, 1'b0, 1'b1, 1'b1, 7'h63);
    cycle();
    chk("burst_rd", 32'(rdd[0]), 32'h61);
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b1, 1'b1, 7'h64);
    cycle();
    chk("rst_count", 32'(cnt[0]), 32'd0);
    chk("rst_rdd", 32'(rdd[0]), 32'd0);
    chk("rst_rv", 32'(rv[0]), 32'd0);
    chk("rst_empty", 32'(em[0]), 32'd1);
    chk("rst_afull", 32'(af[0]), 32'd0);
    rst_n = 1'b1;
    set_in(0, 1'b0, 1'b0, 1'b0, '0);
    cycle();

    // Random traffic with shifting write/read bias to reach both extremes
    for (int i = 0; i < 3000; i++) begin
      int wb;
      int rb;
      wb = ((i / 200) % 2 == 0) ? 75 : 30;
      rb = 100 - wb;
      rst_n = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < 2; k++) begin
        set_in(k, ($urandom_range(0, 63) == 0),
               ($urandom_range(0, 99) < wb),
               ($urandom_range(0, 99) < rb),
               DW'($urandom));
      end
      cycle();
    end

    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the next-generation buffer for same-domain multi-bit data transfer and adds the features the earlier FIFO lacks: full/empty protection, occupancy count, almost-full/almost-empty thresholds, overflow/underflow error pulses, synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and a consumer on one clock and is the standard buffer for new blocks.

Parameters:
DATA_WIDTH, 7, width of each data word
DEPTH, 16, number of entries; power of two, at least 2
AFULL_THRESH, DEPTH-2, almost_full asserted when count >= this value
AEMPTY_THRESH, 2, almost_empty asserted when count <= this value
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of contents; active high
wr_en  input  1  write request
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read/pop request
rd_data  output  DATA_WIDTH  read data
rd_valid  output  1  rd_data is valid
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  one-cycle pulse when a write is rejected
underflow  output  1  one-cycle pulse when a read is rejected

Behaviour:
- One clock domain; reset is synchronous and active-low. On a clk edge with rst_n=0: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. As a result, empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- ADDR_W = $clog2(DEPTH). Pointers are ADDR_W bits wide and wrap naturally from DEPTH-1 to 0. count is ADDR_W+1 bits.
- Write accept: wr_acc = wr_en & ~full. An accepted write stores wr_data at mem[wr_ptr] and increments wr_ptr.
- Read accept: rd_acc = rd_en & ~empty. An accepted read increments rd_ptr.
- full and empty are evaluated on the pre-edge registered state. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- count_next = count + wr_acc - rd_acc. A simultaneous accepted write and read leaves count unchanged.
- All status flags decode combinationally from the registered count, so they update in the same cycle as count.
- overflow is registered and equals wr_en & full from the previous cycle; it asserts for one cycle.
- underflow is registered and equals rd_en & empty from the previous cycle; it asserts for one cycle.
- FWFT=0 (standard mode):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
  - Read latency is 1 cycle.
- FWFT=1 (fall-through mode):
  - rd_data = mem[rd_ptr] (asynchronous read) and rd_valid = ~empty.
  - The head word is visible before rd_en; rd_en pops it.
  - The first word appears 1 cycle after the write that made the FIFO non-empty.
  - rd_data is don't-care while empty.
- flush (with rst_n=1):
  - Same register effect as reset, except rd_data holds its value.
  - Takes priority over wr_en and rd_en in the same cycle.
  - No overflow or underflow pulse is generated in that cycle.
  - overflow/underflow from the previous cycle are cleared.
- Parameter legality: 0 < AEMPTY_THRESH < AFULL_THRESH < DEPTH. An elaboration-time assertion fails otherwise, and also if DEPTH is not a power of two.

Decomposition:
- fifo_pkg holds:
  - function fifo_addr_w(depth), returning $clog2.
  - typedef fifo_status_t: a packed struct of full, empty, almost_full, almost_empty, overflow and underflow, for reuse by future FIFO variants.
- One sub-module, fifo_mem_2p: DEPTH x DATA_WIDTH array with synchronous write and asynchronous read port. The top level holds the pointers, count, flag logic and read register.

Test Plan:
1. Reset then idle; DEPTH=16, FWFT=0 -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0, rd_data=0.
2. Write 0x01..0x10 (16 words), one per cycle -> almost_full rises when count=14, full rises when count=16. A 17th write gives overflow=1 for exactly one cycle and count stays 16. Then 16 reads return 0x01..0x10 in order, each 1 cycle after its rd_en.
3. Hold count at 8 with simultaneous wr_en and rd_en for 40 cycles (pointers wrap twice) -> count stays 8 and output data sequence is intact.
4. Empty FIFO, rd_en=1 with wr_en=1 writing 0x55 -> underflow pulses; next cycle count=1 and empty=0. A subsequent read returns 0x55.
5. FWFT=1: write 0x2A -> next cycle rd_valid=1 and rd_data=0x2A with no rd_en. rd_en=1 for one cycle -> empty=1 and rd_valid=0 the following cycle.
6. count=5, assert flush together with wr_en=1 -> next cycle count=0, empty=1, no overflow. Assert rst_n=0 mid-burst -> all outputs return to reset values on that edge.
